// File: rtl/button_conditioner_if.sv
// ---------------------------------------------------------------------------
// button_conditioner_if
//
// Groups the raw board push-buttons and the conditioned outputs that the
// button conditioner produces for the mode/root controller.
//
// Signals:
//   center_raw, left_raw, right_raw, down_raw : raw, asynchronous, active-high
//   center_but, left_but, right_but, down_but : one-cycle press pulses
//   held[3:0]                                 : debounced levels
//                                               {down, right, left, center}
//
// Modports:
//   master : board / stimulus side (drives raw buttons, observes outputs)
//   slave  : the conditioner itself (reads raw buttons, drives outputs)
// ---------------------------------------------------------------------------
interface button_conditioner_if;
    logic       center_raw;
    logic       left_raw;
    logic       right_raw;
    logic       down_raw;

    logic       center_but;
    logic       left_but;
    logic       right_but;
    logic       down_but;
    logic [3:0] held;

    modport master (
        output center_raw, left_raw, right_raw, down_raw,
        input  center_but, left_but, right_but, down_but, held
    );

    modport slave (
        input  center_raw, left_raw, right_raw, down_raw,
        output center_but, left_but, right_but, down_but, held
    );
endinterface

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Turns the four raw, bouncing board push-buttons (center, left, right, down)
// into clean, synchronized, single-cycle press pulses for the mode/root
// controller, and exports the debounced level of each button.
//
// Every button has its own identical channel:
//   2-flop synchronizer -> debounce FSM (RELEASED / PRESS_WAIT / PRESSED /
//   RELEASE_WAIT) -> registered pulse and registered held level.
// A press pulse appears DEBOUNCE_CYCLES+3 edges after the first edge that
// samples the raw input high; releases never pulse.
//
// Parameters:
//   DEBOUNCE_CYCLES : stable synchronized samples needed to accept a change (>=1)
//   REPEAT_DELAY    : held cycles before the first auto-repeat pulse
//   REPEAT_PERIOD   : cycles between subsequent auto-repeat pulses
//
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   btn   : button_conditioner_if.slave (raw inputs, pulses, held levels)
//
// Optional feature (macro BUTTON_AUTO_REPEAT_EN):
//   When defined, the left and right channels emit additional one-cycle
//   pulses while the button stays PRESSED: the first REPEAT_DELAY cycles
//   after the initial press pulse, then every REPEAT_PERIOD cycles.
//   Center and down never repeat. When undefined, no repeat logic exists.
// ---------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  btn
);

    // One counter width covers the debounce count and the repeat counts, so
    // none of them can ever wrap.
    localparam int MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_ALL = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int CNT_W   = (MAX_ALL < 1) ? 1 : $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0] DEB_VAL = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } chan_state_t;

    // Channel index order matches held: {down, right, left, center}.
    logic [3:0] raw_vec;
    logic [3:0] pulse_vec;
    logic [3:0] held_vec;

    assign raw_vec = {btn.down_raw, btn.right_raw, btn.left_raw, btn.center_raw};

    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
        logic [1:0]       sync_reg;
        logic             samp;
        chan_state_t      state_reg;
        chan_state_t      state_next;
        logic [CNT_W-1:0] cnt_reg;
        logic [CNT_W-1:0] cnt_next;
        logic             pulse_reg;
        logic             pulse_next;
        logic             held_reg;
        logic             held_next;
        logic             rpt_fire;

        // Second synchronizer stage is the only sample the FSM ever sees.
        assign samp = sync_reg[1];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_reg  <= 2'b00;
                state_reg <= RELEASED;
                cnt_reg   <= '0;
                pulse_reg <= 1'b0;
                held_reg  <= 1'b0;
            end else begin
                sync_reg  <= {sync_reg[0], raw_vec[gi]};
                state_reg <= state_next;
                cnt_reg   <= cnt_next;
                pulse_reg <= pulse_next;
                held_reg  <= held_next;
            end
        end

        always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            pulse_next = 1'b0;

            case (state_reg)
                RELEASED: begin
                    if (samp) begin
                        state_next = PRESS_WAIT;
                        cnt_next   = CNT_ONE;
                    end
                end

                PRESS_WAIT: begin
                    if (!samp) begin
                        // Bounce rejected.
                        state_next = RELEASED;
                        cnt_next   = '0;
                    end else if (cnt_reg == DEB_VAL) begin
                        state_next = PRESSED;
                        cnt_next   = '0;
                        pulse_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end

                PRESSED: begin
                    if (!samp) begin
                        state_next = RELEASE_WAIT;
                        cnt_next   = CNT_ONE;
                    end else begin
                        pulse_next = rpt_fire;
                    end
                end

                RELEASE_WAIT: begin
                    if (samp) begin
                        // Release bounce: still pressed, and no new pulse.
                        state_next = PRESSED;
                        cnt_next   = '0;
                    end else if (cnt_reg == DEB_VAL) begin
                        state_next = RELEASED;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end

                default: begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end
            endcase

            // held is registered from the next state so it changes in the
            // same cycle as the registered pulse and never glitches.
            held_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
        end

`ifdef BUTTON_AUTO_REPEAT_EN
        if ((gi == 1) || (gi == 2)) begin : g_rpt
            localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
            localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

            logic [CNT_W-1:0] rpt_cnt_reg;
            logic [CNT_W-1:0] rpt_cnt_next;
            logic             rpt_first_reg;   // 1 until the first repeat has fired
            logic             rpt_first_next;
            logic             fire;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rpt_cnt_reg   <= '0;
                    rpt_first_reg <= 1'b1;
                end else begin
                    rpt_cnt_reg   <= rpt_cnt_next;
                    rpt_first_reg <= rpt_first_next;
                end
            end

            // The counter only runs while the FSM stays in PRESSED; any exit
            // (including a bounce through RELEASE_WAIT) restarts the delay.
            // Firing on count N-1 makes the registered pulse land exactly N
            // cycles after the previous one.
            always_comb begin
                rpt_cnt_next   = '0;
                rpt_first_next = 1'b1;
                fire           = 1'b0;
                if ((state_reg == PRESSED) && samp) begin
                    rpt_first_next = rpt_first_reg;
                    if (rpt_cnt_reg == (rpt_first_reg ? DELAY_LAST : PERIOD_LAST)) begin
                        fire           = 1'b1;
                        rpt_cnt_next   = '0;
                        rpt_first_next = 1'b0;
                    end else begin
                        rpt_cnt_next = rpt_cnt_reg + CNT_ONE;
                    end
                end
            end

            assign rpt_fire = fire;
        end else begin : g_no_rpt
            assign rpt_fire = 1'b0;
        end
`else
        assign rpt_fire = 1'b0;
`endif

        assign pulse_vec[gi] = pulse_reg;
        assign held_vec[gi]  = held_reg;
    end

    assign btn.center_but = pulse_vec[0];
    assign btn.left_but   = pulse_vec[1];
    assign btn.right_but  = pulse_vec[2];
    assign btn.down_but   = pulse_vec[3];
    assign btn.held       = held_vec;

endmodule
